vga_index_tracker: RTL and testbench
====================================

Name: vga_index_tracker

Overview:
- Parametrised successor to the VGA capture index generator. Runs on the AD9880 data clock.
- Derives pixel coordinates (i, j) and a valid strobe from HSOUT/VSOUT, with configurable sync polarity and counter width.
- Adds timing measurement, a frame-lock state machine, line/frame start pulses and a no-sync timeout.
- Feeds the frame-buffer writer, which must write only while the tracker reports lock.

Parameters:
- CW, 11: width of the counters, i, j and the measurement outputs.
- Width, 800: active pixels per line.
- FrontH, 40: horizontal front porch, in clocks.
- PulseH, 128: HSYNC pulse width.
- BackH, 93: horizontal back porch, including the 5-clock AD9880 pipeline skew.
- Height, 600: active lines per frame.
- FrontV, 1: vertical front porch, in lines.
- PulseV, 4: VSYNC pulse width, in lines.
- BackV, 24: vertical back porch, in lines.
- HPol, 1: HSOUT active level (1 = active high).
- VPol, 1: VSOUT active level.
- LockFrames, 2: consecutive good frames required to lock (1..15).

Ports:
- VGA_IN_DATA_CLK  in  1  sole clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- VGA_IN_HSOUT  in  1  horizontal sync from AD9880.
- VGA_IN_VSOUT  in  1  vertical sync from AD9880.
- i  out  CW  active line index = v_counter - (PulseV+BackV), modulo 2^CW.
- j  out  CW  active pixel index = h_counter - (PulseH+BackH), modulo 2^CW.
- valid  out  1  pixel at (i, j) is inside the active window and the tracker is LOCKED.
- line_start  out  1  one-cycle pulse when valid and j==0.
- frame_start  out  1  one-cycle pulse when valid, i==0 and j==0.
- locked  out  1  high exactly while in the LOCKED state.
- htotal_meas  out  CW  last measured line length, in clocks.
- vtotal_meas  out  CW  last measured frame length, in lines.

Behaviour:
- Constants:
  - HTotal = Width + FrontH + PulseH + BackH.
  - VTotal = Height + FrontV + PulseV + BackV.
- Reset (asynchronous):
  - Counters, htotal_meas and vtotal_meas go to 0.
  - Good-frame count goes to 0; state goes to IDLE.
  - Sync history registers go to the active level, so no edge is detected on the first cycle after release.
  - All outputs are 0.
- Edge detection:
  - hs_act = (VGA_IN_HSOUT == HPol); vs_act likewise with VPol.
  - A leading edge is act & !act_prev, where act_prev is the registered copy.
  - The counter reacts at the first clock edge where the input is sampled active: 1-cycle latency, identical to the previous generation.
- Counters:
  - VS edge: h_counter <= 0, v_counter <= 0. VS edge has priority when it coincides with an HS edge.
  - HS edge alone: h_counter <= 0, v_counter <= v_counter + 1, saturating at 2^CW-1.
  - Otherwise: h_counter <= h_counter + 1, saturating at 2^CW-1.
- Measurement:
  - On an HS edge: htotal_meas <= h_counter + 1. Exception: the first HS edge after a VS edge does not update htotal_meas and is excluded from checking.
  - On a VS edge: vtotal_meas <= v_counter + 1.
- State machine:
  - IDLE: counters run but valid is 0. First VS edge -> ACQUIRE with good-frame count = 0.
  - ACQUIRE: a per-frame bad flag is set by any checked line with h_counter+1 != HTotal. On a VS edge the frame is good if the bad flag is clear and v_counter+1 == VTotal. A good frame increments the count; a bad frame clears it. Reaching LockFrames -> LOCKED. The bad flag clears at every VS edge.
  - LOCKED: any checked line mismatch, or a VS edge with v_counter+1 != VTotal, -> ACQUIRE the next cycle with count 0. locked and valid drop on that same transition.
  - Timeout: in any state, h_counter reaching 2^CW-1 (HSYNC lost) -> IDLE.
- Outputs:
  - valid = locked & (PulseH+BackH <= h_counter < PulseH+BackH+Width) & (PulseV+BackV <= v_counter < PulseV+BackV+Height).
  - i, j, valid, line_start and frame_start are combinational from the registered counters and state.
- Mid-frame Reset: returns to IDLE immediately; lock requires LockFrames fresh good frames after the next VS edge.

Optional Feature:
- Macro: VGA_INDEX_AUTOPOL_EN.
- Defined:
  - HPol/VPol are ignored. Each sync's polarity is learned in IDLE: the block counts clocks with the raw input high over one 2^CW-clock window. Majority high means active-low; the polarity register becomes 0.
  - Learned polarity persists until Reset or timeout. IDLE does not accept a VS edge until both polarities are learned.
- Undefined: polarity is fixed by the parameters; no learning logic is synthesised.

Test Plan:
- Bench parameters for all scenarios: Width=16, FrontH=2, PulseH=4, BackH=3 (HTotal 25); Height=8, FrontV=1, PulseV=2, BackV=2 (VTotal 13); LockFrames=2; CW=8.
- Clean video, 3 frames -> locked rises at the 3rd VS edge. frame_start fires at h=7, v=4. htotal_meas=25, vtotal_meas=13. Exactly 128 valid cycles per locked frame.
- Lock, then one line of 26 clocks -> locked=0 and valid=0 the cycle after that line's HS edge. Relocks after 2 further good frames.
- Coincident HS and VS edges -> both counters are 0 the next cycle. v_counter does not become 1.
- HSYNC held inactive for 255 clocks -> state IDLE, locked=0. After sync resumes, a VS edge is needed before ACQUIRE.
- Reset asserted mid-line while locked -> all outputs 0 asynchronously, before the next clock edge. No spurious edge on release with sync held active.
- VGA_INDEX_AUTOPOL_EN defined, HSOUT/VSOUT inverted (active-low) -> same lock timing and values as the clean-video scenario, plus the learning window.

Source files
------------

// File: rtl/vga_index_tracker_if.sv
// Sync inputs and index/strobe/measurement outputs of the VGA index tracker.
interface vga_index_tracker_if #(parameter int CW = 11);
  logic          VGA_IN_HSOUT;
  logic          VGA_IN_VSOUT;
  logic [CW-1:0] i;
  logic [CW-1:0] j;
  logic          valid;
  logic          line_start;
  logic          frame_start;
  logic          locked;
  logic [CW-1:0] htotal_meas;
  logic [CW-1:0] vtotal_meas;

  modport master (
    output VGA_IN_HSOUT, VGA_IN_VSOUT,
    input  i, j, valid, line_start, frame_start, locked, htotal_meas, vtotal_meas
  );

  modport slave (
    input  VGA_IN_HSOUT, VGA_IN_VSOUT,
    output i, j, valid, line_start, frame_start, locked, htotal_meas, vtotal_meas
  );
endinterface

// File: rtl/vga_index_tracker.sv
// Pixel index tracker for AD9880 capture: sync-driven counters, timing measurement and frame lock.
// Optional sync polarity learning is built when VGA_INDEX_AUTOPOL_EN is defined.
module vga_index_tracker #(
  parameter int CW         = 11,
  parameter int Width      = 800,
  parameter int FrontH     = 40,
  parameter int PulseH     = 128,
  parameter int BackH      = 93,
  parameter int Height     = 600,
  parameter int FrontV     = 1,
  parameter int PulseV     = 4,
  parameter int BackV      = 24,
  parameter int HPol       = 1,
  parameter int VPol       = 1,
  parameter int LockFrames = 2
) (
  input logic                VGA_IN_DATA_CLK,
  input logic                Reset,
  vga_index_tracker_if.slave vga
);
  localparam logic [CW:0]   HTOT    = (CW+1)'(Width + FrontH + PulseH + BackH);
  localparam logic [CW:0]   VTOT    = (CW+1)'(Height + FrontV + PulseV + BackV);
  localparam logic [CW-1:0] H_START = CW'(PulseH + BackH);
  localparam logic [CW-1:0] H_END   = CW'(PulseH + BackH + Width);
  localparam logic [CW-1:0] V_START = CW'(PulseV + BackV);
  localparam logic [CW-1:0] V_END   = CW'(PulseV + BackV + Height);
  localparam logic [CW-1:0] CMAX    = {CW{1'b1}};
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW:0]   ONE_W   = (CW+1)'(1);
  localparam logic [4:0]    LOCK_N  = 5'(LockFrames);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t        state;
  logic [CW-1:0] h_cnt, v_cnt, ht_q, vt_q;
  logic [CW:0]   h_inc, v_inc;
  logic          hs_raw_q, vs_raw_q, hpol, vpol, pol_ok;
  logic          hs_edge, vs_edge, skip_line, bad, line_bad, frame_ok, lock_q;
  logic [3:0]    good_cnt;

  // History holds raw levels so a polarity change never fabricates an edge.
  assign hs_edge  = (vga.VGA_IN_HSOUT == hpol) & (hs_raw_q != hpol);
  assign vs_edge  = (vga.VGA_IN_VSOUT == vpol) & (vs_raw_q != vpol);
  assign h_inc    = {1'b0, h_cnt} + ONE_W;
  assign v_inc    = {1'b0, v_cnt} + ONE_W;
  assign line_bad = hs_edge & ~vs_edge & ~skip_line & (h_inc != HTOT);
  assign frame_ok = ~bad & (v_inc == VTOT);

`ifdef VGA_INDEX_AUTOPOL_EN
  localparam logic [CW:0] HALF = (CW+1)'(1) << (CW-1);
  logic [CW-1:0] win_cnt;
  logic [CW:0]   hs_hi, vs_hi, hs_hi_nxt, vs_hi_nxt;
  logic          hs_rst_lvl, vs_rst_lvl;

  assign hs_rst_lvl = 1'b1;
  assign vs_rst_lvl = 1'b1;
  assign hs_hi_nxt  = hs_hi + {{CW{1'b0}}, vga.VGA_IN_HSOUT};
  assign vs_hi_nxt  = vs_hi + {{CW{1'b0}}, vga.VGA_IN_VSOUT};

  // Mostly-high sync over one full window means the pulse is active-low.
  always_ff @(posedge VGA_IN_DATA_CLK or posedge Reset) begin
    if (Reset) begin
      hpol <= 1'b1; vpol <= 1'b1; pol_ok <= 1'b0;
      win_cnt <= '0; hs_hi <= '0; vs_hi <= '0;
    end else if (h_cnt == CMAX) begin
      pol_ok <= 1'b0; win_cnt <= '0; hs_hi <= '0; vs_hi <= '0;
    end else if (state == IDLE && !pol_ok) begin
      win_cnt <= win_cnt + ONE_C;
      if (win_cnt == CMAX) begin
        hpol   <= ~(hs_hi_nxt > HALF);
        vpol   <= ~(vs_hi_nxt > HALF);
        pol_ok <= 1'b1;
        hs_hi  <= '0;
        vs_hi  <= '0;
      end else begin
        hs_hi <= hs_hi_nxt;
        vs_hi <= vs_hi_nxt;
      end
    end
  end
`else
  logic hs_rst_lvl, vs_rst_lvl;
  assign hpol       = (HPol != 0);
  assign vpol       = (VPol != 0);
  assign pol_ok     = 1'b1;
  assign hs_rst_lvl = (HPol != 0);
  assign vs_rst_lvl = (VPol != 0);
`endif

  always_ff @(posedge VGA_IN_DATA_CLK or posedge Reset) begin
    if (Reset) begin
      hs_raw_q <= hs_rst_lvl; vs_raw_q <= vs_rst_lvl;
      h_cnt <= '0; v_cnt <= '0; ht_q <= '0; vt_q <= '0; skip_line <= 1'b0;
    end else begin
      hs_raw_q <= vga.VGA_IN_HSOUT;
      vs_raw_q <= vga.VGA_IN_VSOUT;
      if (vs_edge) begin
        h_cnt <= '0; v_cnt <= '0; vt_q <= v_inc[CW-1:0]; skip_line <= 1'b1;
      end else if (hs_edge) begin
        h_cnt     <= '0;
        skip_line <= 1'b0;
        if (v_cnt != CMAX) v_cnt <= v_cnt + ONE_C;
        if (!skip_line)    ht_q  <= h_inc[CW-1:0];
      end else if (h_cnt != CMAX) begin
        h_cnt <= h_cnt + ONE_C;
      end
    end
  end

  // A saturated line counter means HSYNC is gone; that overrides every state.
  always_ff @(posedge VGA_IN_DATA_CLK or posedge Reset) begin
    if (Reset) begin
      state <= IDLE; lock_q <= 1'b0; good_cnt <= '0; bad <= 1'b0;
    end else if (h_cnt == CMAX) begin
      state <= IDLE; lock_q <= 1'b0; good_cnt <= '0; bad <= 1'b0;
    end else begin
      if (vs_edge)       bad <= 1'b0;
      else if (line_bad) bad <= 1'b1;
      case (state)
        IDLE: if (vs_edge && pol_ok) begin
          state <= ACQUIRE; good_cnt <= '0;
        end
        ACQUIRE: if (vs_edge) begin
          if (frame_ok) begin
            good_cnt <= good_cnt + 4'd1;
            if ({1'b0, good_cnt} + 5'd1 >= LOCK_N) begin
              state <= LOCKED; lock_q <= 1'b1;
            end
          end else begin
            good_cnt <= '0;
          end
        end
        LOCKED: if (line_bad || (vs_edge && v_inc != VTOT)) begin
          state <= ACQUIRE; lock_q <= 1'b0; good_cnt <= '0;
        end
        default: begin
          state <= IDLE; lock_q <= 1'b0;
        end
      endcase
    end
  end

  logic          in_win;
  logic [CW-1:0] i_w, j_w;
  assign in_win = (h_cnt >= H_START) && (h_cnt < H_END) && (v_cnt >= V_START) && (v_cnt < V_END);
  // Indices are held at zero while unlocked so every output is quiet out of reset.
  assign i_w             = lock_q ? v_cnt - V_START : '0;
  assign j_w             = lock_q ? h_cnt - H_START : '0;
  assign vga.i           = i_w;
  assign vga.j           = j_w;
  assign vga.valid       = lock_q & in_win;
  assign vga.line_start  = lock_q & in_win & (j_w == '0);
  assign vga.frame_start = lock_q & in_win & (j_w == '0) & (i_w == '0);
  assign vga.locked      = lock_q;
  assign vga.htotal_meas = ht_q;
  assign vga.vtotal_meas = vt_q;
endmodule

// File: tb/tb_vga_index_tracker.sv
// Directed bench for vga_index_tracker: lock, line error, timeout and mid-line reset.
module tb_vga_index_tracker;
  localparam int CW = 8, HT = 25, VT = 13, PH = 4, PV = 2;
`ifdef VGA_INDEX_AUTOPOL_EN
  localparam logic HA = 1'b0, VA = 1'b0;
`else
  localparam logic HA = 1'b1, VA = 1'b1;
`endif

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  vga_index_tracker_if #(.CW(CW)) vif();
  vga_index_tracker #(
    .CW(CW), .Width(16), .FrontH(2), .PulseH(4), .BackH(3),
    .Height(8), .FrontV(1), .PulseV(2), .BackV(2),
    .HPol(1), .VPol(1), .LockFrames(2)
  ) dut (
    .VGA_IN_DATA_CLK(clk),
    .Reset(rst),
    .vga(vif.slave)
  );

  int errs = 0, checks = 0;
  int nvalid, nls, fs_l, fs_c, ij_err, fall_l, fall_c;
  logic lk0, was_lk;
  logic [7:0] i0, j0, ht6;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one clock of sync (in active-level terms) and sample just after the edge.
  task automatic drive(input bit hs, input bit vs);
    vif.VGA_IN_HSOUT = hs ? HA : ~HA;
    vif.VGA_IN_VSOUT = vs ? VA : ~VA;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int long_l, input int stop_l);
    nvalid = 0; nls = 0; fs_l = -1; fs_c = -1; ij_err = 0; fall_l = -1; fall_c = -1;
    for (int l = 0; l < VT; l++) begin
      for (int c = 0; c < ((l == long_l) ? HT + 1 : HT); c++) begin
        if (l == stop_l && c == 10) return;
        drive(c < PH, l < PV);
        if (l == 0 && c == 0) begin lk0 = vif.locked; i0 = vif.i; j0 = vif.j; end
        if (l == 6 && c == 0) ht6 = vif.htotal_meas;
        if (vif.valid) begin
          nvalid++;
          if (vif.i != 8'(l - 4) || vif.j != 8'(c - 7)) ij_err++;
        end
        if (vif.line_start) nls++;
        if (vif.frame_start) begin fs_l = l; fs_c = c; end
        if (was_lk && !vif.locked && fall_l < 0) begin fall_l = l; fall_c = c; end
        was_lk = vif.locked;
      end
    end
  endtask

  initial begin
    vif.VGA_IN_HSOUT = ~HA; vif.VGA_IN_VSOUT = ~VA; was_lk = 1'b0;
    #12;
    chk("rst_locked", vif.locked, 0);
    chk("rst_valid", vif.valid, 0);
    chk("rst_i", vif.i, 0);
    chk("rst_j", vif.j, 0);
    chk("rst_htotal", vif.htotal_meas, 0);
    chk("rst_vtotal", vif.vtotal_meas, 0);
    rst = 1'b0;
    for (int n = 0; n < 20 * HT; n++) drive((n % HT) < PH, 1'b0);
    chk("idle_locked", vif.locked, 0);

    frame(-1, -1);
    chk("f0_lk", lk0, 0);
    chk("f0_valid", nvalid, 0);
    frame(-1, -1);
    chk("f1_lk", lk0, 0);
    chk("f1_vtotal", vif.vtotal_meas, 13);
    frame(-1, -1);
    chk("f2_lk", lk0, 1);
    chk("f2_valid", nvalid, 128);
    chk("f2_fs_line", fs_l, 4);
    chk("f2_fs_col", fs_c, 7);
    chk("f2_line_starts", nls, 8);
    chk("f2_ij", ij_err, 0);
    chk("coinc_i", i0, 252);
    chk("coinc_j", j0, 249);
    chk("f2_htotal", vif.htotal_meas, 25);
    chk("f2_vtotal", vif.vtotal_meas, 13);

    frame(5, -1);
    chk("f3_lk", lk0, 1);
    chk("f3_valid", nvalid, 32);
    chk("f3_fall_line", fall_l, 6);
    chk("f3_fall_col", fall_c, 0);
    chk("f3_long_meas", ht6, 26);
    frame(-1, -1);
    chk("f4_lk", lk0, 0);
    chk("f4_htotal", vif.htotal_meas, 25);
    frame(-1, -1);
    chk("f5_lk", lk0, 0);
    frame(-1, -1);
    chk("f6_lk", lk0, 1);
    chk("f6_valid", nvalid, 128);

    for (int n = 0; n < 200; n++) drive(1'b0, 1'b0);
    chk("hs_lost_200", vif.locked, 1);
    for (int n = 0; n < 60; n++) drive(1'b0, 1'b0);
    chk("timeout", vif.locked, 0);
    for (int n = 0; n < 12 * HT; n++) drive((n % HT) < PH, 1'b0);
    chk("resume_no_vs", vif.locked, 0);
    frame(-1, -1);
    chk("g0_lk", lk0, 0);
    frame(-1, -1);
    chk("g1_lk", lk0, 0);
    frame(-1, -1);
    chk("g2_lk", lk0, 1);

    frame(-1, 5);
    chk("pre_rst_valid", vif.valid, 1);
    chk("pre_rst_i", vif.i, 1);
    chk("pre_rst_j", vif.j, 2);
    #1 rst = 1'b1;
    #1;
    chk("async_locked", vif.locked, 0);
    chk("async_valid", vif.valid, 0);
    chk("async_i", vif.i, 0);
    chk("async_j", vif.j, 0);
    chk("async_ls", vif.line_start, 0);
    chk("async_fs", vif.frame_start, 0);
    chk("async_htotal", vif.htotal_meas, 0);
    chk("async_vtotal", vif.vtotal_meas, 0);
    vif.VGA_IN_HSOUT = HA; vif.VGA_IN_VSOUT = VA;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) drive(1'b1, 1'b1);
    chk("release_vtotal", vif.vtotal_meas, 0);
    chk("release_htotal", vif.htotal_meas, 0);
    chk("release_locked", vif.locked, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
